main_ctrl_fsm: RTL and testbench
================================

MAIN_CTRL_FSM -- requirements
Module: main_ctrl_fsm

Interface
REQ-001 SHALL have parameter SUPPORT_M, default 1, meaning RV32M opcodes (R type, funct7=0000001) are legal and use the mul/div handshake.
REQ-002 SHALL have parameter SUPPORT_SYS, default 1, meaning ecall/ebreak (opcode 1110011, funct3=000) are legal and raise a trap.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 255, range 1..65535, meaning the maximum number of memory wait cycles before a timeout trap.
REQ-004 SHALL have ports i_clk in 1, the single clock; i_rst in 1, reset.
REQ-005 SHALL have inputs i_opcode 7, i_funct3 3, i_funct7 7 (instruction register fields), i_memReady 1, i_mdDone 1.
REQ-006 SHALL have outputs o_state 3, o_memReq 1, o_memWrite 1, o_iFetch 1, o_irWrite 1, o_pcWrite 1, o_regWrite 1, o_mdStart 1, o_trap 1, o_trapCause 2.
REQ-007 SHALL have outputs o_ALUOp 2, o_ALUSrc 1, o_immSrc 3, o_immPlusSrc 1, o_isLoadSigned 1, o_resultSrc 2, o_branch 1, o_jal 1, o_jalr 1.
REQ-008 SHALL use one clock, i_clk; reset i_rst is synchronous and active-high.

Function
REQ-009 SHALL encode states as RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, MULDIV=5, WB=6, TRAP=7, with o_state equal to the current state.
REQ-010 SHALL go RST->FETCH unconditionally after one cycle, with all outputs 0 in RST.
REQ-011 In FETCH it SHALL assert o_memReq and o_iFetch; on i_memReady it SHALL pulse o_irWrite and go to DECODE.
REQ-012 In DECODE it SHALL latch the control fields from i_opcode/i_funct3/i_funct7; those fields SHALL be held stable from EXEC until the next DECODE.
REQ-013 Field encodings: o_ALUOp 00 add, 01 branch compare, 10 funct-based, 11 mul/div.
REQ-014 Field encodings: o_immSrc 000 load, 001 I-arith, 010 shift-imm (funct3[1:0]=01), 011 S, 100 U, 101 B, 110 jalr, 111 J.
REQ-015 Field encodings: o_resultSrc 00 ALU, 01 memory, 10 imm-plus, 11 pc+4.
REQ-016 SHALL derive o_isLoadSigned = funct3[2] and o_immPlusSrc = ~opcode[5].
REQ-017 From DECODE: opcode 0000000 or fence (0001111) SHALL pulse o_pcWrite and go to FETCH; an illegal opcode, or a disabled-feature opcode, SHALL go to TRAP with cause 00; ecall/ebreak with SUPPORT_SYS=1 SHALL go to TRAP with cause 01; all others SHALL go to EXEC.
REQ-018 EXEC, B type: SHALL assert o_branch and o_pcWrite for one cycle, then go to FETCH.
REQ-019 EXEC, load/store: SHALL go to MEM.
REQ-020 EXEC, M op: SHALL pulse o_mdStart for one cycle, then go to MULDIV.
REQ-021 EXEC, all other instructions: SHALL go to WB.
REQ-022 In MEM it SHALL assert o_memReq, with o_memWrite=1 for S type; on i_memReady a store SHALL pulse o_pcWrite and go to FETCH, and a load SHALL go to WB.
REQ-023 MULDIV SHALL wait for i_mdDone, then go to WB; MULDIV has no timeout.
REQ-024 WB SHALL assert o_regWrite for one cycle (with o_jal/o_jalr for J/jalr) plus o_pcWrite, then go to FETCH.
REQ-025 A wait counter (width clog2(MEM_TIMEOUT+1)) SHALL clear on entry to FETCH/MEM and increment each cycle i_memReady=0; on reaching MEM_TIMEOUT it SHALL go to TRAP, cause 10 (FETCH) or 11 (MEM).
REQ-026 If i_memReady=1 in the same cycle the counter reaches MEM_TIMEOUT, ready SHALL win and no trap occurs.
REQ-027 TRAP SHALL assert o_trap and o_pcWrite for one cycle with o_trapCause valid, then go to FETCH; o_trapCause SHALL hold its value until the next trap.
REQ-028 Outside their stated states o_memReq, o_memWrite, o_irWrite, o_pcWrite, o_regWrite, o_mdStart and o_trap SHALL be 0; o_memWrite SHALL never be 1 while o_iFetch=1.

Reset
REQ-029 On i_rst=1 at a clock edge, from any state including mid-MEM or MULDIV, it SHALL enter RST, clear the counter, all latched fields and o_trapCause, and drive every output 0 on the following cycle.
REQ-030 No memory write SHALL be issued in the cycle after reset is applied.

Verification
REQ-031 Reset, then add (0110011, f7=0) with memReady on the first fetch cycle -> states 0,1,2,3,6,1; o_regWrite=1 only in WB; o_ALUOp=10.
REQ-032 sw (0100011) with MEM ready after 3 cycles -> o_memReq=1, o_memWrite=1 for 4 MEM cycles, then o_pcWrite pulse, back to FETCH, o_regWrite never 1.
REQ-033 MEM_TIMEOUT=4, FETCH with memReady held 0 -> TRAP on the 5th cycle, o_trapCause=10, o_trap one cycle; memReady rising on the timeout cycle -> no trap.
REQ-034 SUPPORT_M=0, mul (f7=0000001) -> TRAP cause 00; SUPPORT_M=1 -> o_mdStart single pulse, MULDIV held until i_mdDone, then WB.
REQ-035 i_rst asserted during MULDIV and during a load in MEM -> next cycle o_state=0, all outputs 0, then FETCH.

Source files
------------

// File: rtl/main_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// main_ctrl_fsm
//
// Multi-cycle control sequencer for an RV32I core with optional RV32M and
// ecall/ebreak support. It walks each instruction through
// FETCH -> DECODE -> EXEC -> (MEM | MULDIV) -> WB.
// Decoded control fields are captured at the end of DECODE and stay stable
// until the next DECODE.
// FETCH and MEM share a wait counter. If memory does not answer within
// MEM_TIMEOUT cycles, the sequencer raises a timeout trap.
//
// Parameters
//   SUPPORT_M    : 1 = RV32M ops are legal and use the mul/div handshake
//   SUPPORT_SYS  : 1 = ecall/ebreak are legal and raise a trap (cause 01)
//   MEM_TIMEOUT  : memory wait cycles before a timeout trap (1..65535)
//
// Ports
//   i_clk, i_rst         : clock and synchronous active-high reset
//   i_opcode/funct3/7    : instruction register fields, sampled in DECODE
//   i_memReady           : memory handshake for fetch and data access
//   i_mdDone             : mul/div unit completion
//   o_state              : current state (RST=0 .. TRAP=7)
//   o_memReq, o_memWrite, o_iFetch, o_irWrite : memory/IR control
//   o_pcWrite, o_regWrite, o_mdStart          : datapath strobes
//   o_trap, o_trapCause                       : trap pulse and held cause
//   o_ALUOp, o_ALUSrc, o_immSrc, o_immPlusSrc, o_isLoadSigned,
//   o_resultSrc                               : latched decode fields
//   o_branch, o_jal, o_jalr                   : control-flow strobes
// -----------------------------------------------------------------------------
module main_ctrl_fsm #(
    parameter int SUPPORT_M   = 1,
    parameter int SUPPORT_SYS = 1,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    input  logic       i_memReady,
    input  logic       i_mdDone,
    output logic [2:0] o_state,
    output logic       o_memReq,
    output logic       o_memWrite,
    output logic       o_iFetch,
    output logic       o_irWrite,
    output logic       o_pcWrite,
    output logic       o_regWrite,
    output logic       o_mdStart,
    output logic       o_trap,
    output logic [1:0] o_trapCause,
    output logic [1:0] o_ALUOp,
    output logic       o_ALUSrc,
    output logic [2:0] o_immSrc,
    output logic       o_immPlusSrc,
    output logic       o_isLoadSigned,
    output logic [1:0] o_resultSrc,
    output logic       o_branch,
    output logic       o_jal,
    output logic       o_jalr
);

    // State encoding
    localparam logic [2:0] ST_RST    = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_MULDIV = 3'd5;
    localparam logic [2:0] ST_WB     = 3'd6;
    localparam logic [2:0] ST_TRAP   = 3'd7;

    // Opcodes
    localparam logic [6:0] OP_NOP    = 7'b0000000;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    // Where DECODE sends the instruction
    localparam logic [1:0] CLS_EXEC    = 2'd0;
    localparam logic [1:0] CLS_SKIP    = 2'd1;
    localparam logic [1:0] CLS_ILLEGAL = 2'd2;
    localparam logic [1:0] CLS_SYS     = 2'd3;

    // Trap causes
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b00;
    localparam logic [1:0] CAUSE_SYSCALL  = 2'b01;
    localparam logic [1:0] CAUSE_FETCH_TO = 2'b10;
    localparam logic [1:0] CAUSE_MEM_TO   = 2'b11;

    localparam int              CNT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(MEM_TIMEOUT);

    logic [2:0]       state_q, state_nxt;
    logic [CNT_W-1:0] wait_cnt_q;
    logic [1:0]       trap_cause_q, trap_cause_nxt;

    // Decode results (combinational, from the IR fields)
    logic [1:0] dec_class;
    logic [1:0] dec_alu_op;
    logic       dec_alu_src;
    logic [2:0] dec_imm_src;
    logic [1:0] dec_result_src;
    logic       dec_branch, dec_jal, dec_jalr;
    logic       dec_load, dec_store, dec_md;

    // Fields latched at the end of DECODE
    logic [1:0] alu_op_q;
    logic       alu_src_q;
    logic [2:0] imm_src_q;
    logic       imm_plus_src_q;
    logic       load_signed_q;
    logic [1:0] result_src_q;
    logic       is_branch_q, is_jal_q, is_jalr_q;
    logic       is_load_q, is_store_q, is_md_q;

    logic wait_expired;

    // -------------------------------------------------------------------------
    // Instruction decode
    // -------------------------------------------------------------------------
    always_comb begin
        dec_class      = CLS_EXEC;
        dec_alu_op     = 2'b00;
        dec_alu_src    = 1'b0;
        dec_imm_src    = 3'b000;
        dec_result_src = 2'b00;
        dec_branch     = 1'b0;
        dec_jal        = 1'b0;
        dec_jalr       = 1'b0;
        dec_load       = 1'b0;
        dec_store      = 1'b0;
        dec_md         = 1'b0;
        unique case (i_opcode)
            OP_NOP, OP_FENCE: dec_class = CLS_SKIP;
            OP_LOAD: begin
                dec_alu_src    = 1'b1;
                dec_imm_src    = 3'b000;
                dec_result_src = 2'b01;
                dec_load       = 1'b1;
            end
            OP_STORE: begin
                dec_alu_src = 1'b1;
                dec_imm_src = 3'b011;
                dec_store   = 1'b1;
            end
            OP_IMM: begin
                dec_alu_op  = 2'b10;
                dec_alu_src = 1'b1;
                // slli/srli/srai carry a shamt instead of a full immediate
                dec_imm_src = (i_funct3[1:0] == 2'b01) ? 3'b010 : 3'b001;
            end
            OP_REG: begin
                if (i_funct7 == F7_BASE || i_funct7 == F7_ALT) begin
                    dec_alu_op = 2'b10;
                end else if (i_funct7 == F7_MUL && SUPPORT_M != 0) begin
                    dec_alu_op = 2'b11;
                    dec_md     = 1'b1;
                end else begin
                    dec_class = CLS_ILLEGAL;
                end
            end
            OP_LUI, OP_AUIPC: begin
                dec_imm_src    = 3'b100;
                dec_result_src = 2'b10;
            end
            OP_BRANCH: begin
                dec_alu_op  = 2'b01;
                dec_imm_src = 3'b101;
                dec_branch  = 1'b1;
            end
            OP_JALR: begin
                dec_alu_src    = 1'b1;
                dec_imm_src    = 3'b110;
                dec_result_src = 2'b11;
                dec_jalr       = 1'b1;
            end
            OP_JAL: begin
                dec_imm_src    = 3'b111;
                dec_result_src = 2'b11;
                dec_jal        = 1'b1;
            end
            OP_SYSTEM: begin
                // funct3=000 selects ecall/ebreak; any other funct3 is illegal
                if (i_funct3 == 3'b000 && SUPPORT_SYS != 0)
                    dec_class = CLS_SYS;
                else
                    dec_class = CLS_ILLEGAL;
            end
            default: dec_class = CLS_ILLEGAL;
        endcase
    end

    // The timeout fires when this cycle's increment would reach MEM_TIMEOUT.
    // A ready in the same cycle takes priority.
    assign wait_expired = !i_memReady && (wait_cnt_q == TIMEOUT_V - CNT_W'(1));

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt      = state_q;
        trap_cause_nxt = trap_cause_q;
        unique case (state_q)
            ST_RST: state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (i_memReady) begin
                    state_nxt = ST_DECODE;
                end else if (wait_expired) begin
                    state_nxt      = ST_TRAP;
                    trap_cause_nxt = CAUSE_FETCH_TO;
                end
            end
            ST_DECODE: begin
                unique case (dec_class)
                    CLS_SKIP: state_nxt = ST_FETCH;
                    CLS_ILLEGAL: begin
                        state_nxt      = ST_TRAP;
                        trap_cause_nxt = CAUSE_ILLEGAL;
                    end
                    CLS_SYS: begin
                        state_nxt      = ST_TRAP;
                        trap_cause_nxt = CAUSE_SYSCALL;
                    end
                    default: state_nxt = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                if (is_branch_q)
                    state_nxt = ST_FETCH;
                else if (is_load_q || is_store_q)
                    state_nxt = ST_MEM;
                else if (is_md_q)
                    state_nxt = ST_MULDIV;
                else
                    state_nxt = ST_WB;
            end
            ST_MEM: begin
                if (i_memReady) begin
                    state_nxt = is_store_q ? ST_FETCH : ST_WB;
                end else if (wait_expired) begin
                    state_nxt      = ST_TRAP;
                    trap_cause_nxt = CAUSE_MEM_TO;
                end
            end
            ST_MULDIV: begin
                if (i_mdDone)
                    state_nxt = ST_WB;
            end
            ST_WB:   state_nxt = ST_FETCH;
            ST_TRAP: state_nxt = ST_FETCH;
            default: state_nxt = ST_RST;
        endcase
    end

    // -------------------------------------------------------------------------
    // State, wait counter and trap cause
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_RST;
            wait_cnt_q   <= '0;
            trap_cause_q <= 2'b00;
        end else begin
            state_q <= state_nxt;
            // Every entry into FETCH or MEM comes from a different state,
            // so any state change restarts the count.
            if (state_nxt != state_q)
                wait_cnt_q <= '0;
            else if ((state_q == ST_FETCH || state_q == ST_MEM) && !i_memReady)
                wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            if (state_nxt == ST_TRAP)
                trap_cause_q <= trap_cause_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Decode field latch (captured once, at the end of DECODE)
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            alu_op_q       <= 2'b00;
            alu_src_q      <= 1'b0;
            imm_src_q      <= 3'b000;
            imm_plus_src_q <= 1'b0;
            load_signed_q  <= 1'b0;
            result_src_q   <= 2'b00;
            is_branch_q    <= 1'b0;
            is_jal_q       <= 1'b0;
            is_jalr_q      <= 1'b0;
            is_load_q      <= 1'b0;
            is_store_q     <= 1'b0;
            is_md_q        <= 1'b0;
        end else if (state_q == ST_DECODE) begin
            alu_op_q       <= dec_alu_op;
            alu_src_q      <= dec_alu_src;
            imm_src_q      <= dec_imm_src;
            imm_plus_src_q <= ~i_opcode[5];
            load_signed_q  <= i_funct3[2];
            result_src_q   <= dec_result_src;
            is_branch_q    <= dec_branch;
            is_jal_q       <= dec_jal;
            is_jalr_q      <= dec_jalr;
            is_load_q      <= dec_load;
            is_store_q     <= dec_store;
            is_md_q        <= dec_md;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_state     = state_q;
    assign o_memReq    = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign o_iFetch    = (state_q == ST_FETCH);
    // Only asserted in MEM, so it can never overlap with o_iFetch
    assign o_memWrite  = (state_q == ST_MEM) && is_store_q;
    assign o_irWrite   = (state_q == ST_FETCH) && i_memReady;
    assign o_pcWrite   = ((state_q == ST_DECODE) && (dec_class == CLS_SKIP))
                       || ((state_q == ST_EXEC) && is_branch_q)
                       || ((state_q == ST_MEM) && i_memReady && is_store_q)
                       || (state_q == ST_WB)
                       || (state_q == ST_TRAP);
    assign o_regWrite  = (state_q == ST_WB);
    assign o_mdStart   = (state_q == ST_EXEC) && is_md_q;
    assign o_trap      = (state_q == ST_TRAP);
    assign o_trapCause = trap_cause_q;

    assign o_branch    = (state_q == ST_EXEC) && is_branch_q;
    assign o_jal       = (state_q == ST_WB) && is_jal_q;
    assign o_jalr      = (state_q == ST_WB) && is_jalr_q;

    assign o_ALUOp        = alu_op_q;
    assign o_ALUSrc       = alu_src_q;
    assign o_immSrc       = imm_src_q;
    assign o_immPlusSrc   = imm_plus_src_q;
    assign o_isLoadSigned = load_signed_q;
    assign o_resultSrc    = result_src_q;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_main_ctrl_fsm
//
// Directed bench for main_ctrl_fsm.
// Instance a uses SUPPORT_M=1, SUPPORT_SYS=1 and MEM_TIMEOUT=4, so that
// timeout boundaries are reached quickly.
// Instance b uses SUPPORT_M=0, SUPPORT_SYS=0 and the default MEM_TIMEOUT.
// Both instances share the clock, the reset and all inputs.
// -----------------------------------------------------------------------------
module tb_main_ctrl_fsm;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       mem_ready;
    logic       md_done;

    logic [2:0] a_state, b_state;
    logic       a_mem_req, a_mem_write, a_ifetch, a_ir_write, a_pc_write, a_reg_write;
    logic       a_md_start, a_trap, a_alu_src, a_imm_plus_src, a_load_signed;
    logic       a_branch, a_jal, a_jalr;
    logic [1:0] a_trap_cause, a_alu_op, a_result_src;
    logic [2:0] a_imm_src;
    logic       b_mem_req, b_mem_write, b_ifetch, b_ir_write, b_pc_write, b_reg_write;
    logic       b_md_start, b_trap, b_alu_src, b_imm_plus_src, b_load_signed;
    logic       b_branch, b_jal, b_jalr;
    logic [1:0] b_trap_cause, b_alu_op, b_result_src;
    logic [2:0] b_imm_src;

    logic [25:0] a_all, b_all;
    assign a_all = {a_state, a_mem_req, a_mem_write, a_ifetch, a_ir_write, a_pc_write,
                    a_reg_write, a_md_start, a_trap, a_trap_cause, a_alu_op, a_alu_src,
                    a_imm_src, a_imm_plus_src, a_load_signed, a_result_src, a_branch,
                    a_jal, a_jalr};
    assign b_all = {b_state, b_mem_req, b_mem_write, b_ifetch, b_ir_write, b_pc_write,
                    b_reg_write, b_md_start, b_trap, b_trap_cause, b_alu_op, b_alu_src,
                    b_imm_src, b_imm_plus_src, b_load_signed, b_result_src, b_branch,
                    b_jal, b_jalr};

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    main_ctrl_fsm #(.SUPPORT_M(1), .SUPPORT_SYS(1), .MEM_TIMEOUT(4)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_funct3(funct3), .i_funct7(funct7),
        .i_memReady(mem_ready), .i_mdDone(md_done),
        .o_state(a_state), .o_memReq(a_mem_req), .o_memWrite(a_mem_write),
        .o_iFetch(a_ifetch), .o_irWrite(a_ir_write), .o_pcWrite(a_pc_write),
        .o_regWrite(a_reg_write), .o_mdStart(a_md_start), .o_trap(a_trap),
        .o_trapCause(a_trap_cause), .o_ALUOp(a_alu_op), .o_ALUSrc(a_alu_src),
        .o_immSrc(a_imm_src), .o_immPlusSrc(a_imm_plus_src),
        .o_isLoadSigned(a_load_signed), .o_resultSrc(a_result_src),
        .o_branch(a_branch), .o_jal(a_jal), .o_jalr(a_jalr)
    );

    main_ctrl_fsm #(.SUPPORT_M(0), .SUPPORT_SYS(0), .MEM_TIMEOUT(255)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_funct3(funct3), .i_funct7(funct7),
        .i_memReady(mem_ready), .i_mdDone(md_done),
        .o_state(b_state), .o_memReq(b_mem_req), .o_memWrite(b_mem_write),
        .o_iFetch(b_ifetch), .o_irWrite(b_ir_write), .o_pcWrite(b_pc_write),
        .o_regWrite(b_reg_write), .o_mdStart(b_md_start), .o_trap(b_trap),
        .o_trapCause(b_trap_cause), .o_ALUOp(b_alu_op), .o_ALUSrc(b_alu_src),
        .o_immSrc(b_imm_src), .o_immPlusSrc(b_imm_plus_src),
        .o_isLoadSigned(b_load_signed), .o_resultSrc(b_result_src),
        .o_branch(b_branch), .o_jal(b_jal), .o_jalr(b_jalr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 2 time units after the edge
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; opcode = '0; funct3 = '0; funct7 = '0; mem_ready = 1'b0; md_done = 1'b0;
        cyc(); cyc();
        chk("rst_state", 32'(a_state), 0);
        chk("rst_outs_a", 32'(a_all), 0);
        chk("rst_outs_b", 32'(b_all), 0);
        rst = 1'b0;
        cyc();

        // add: FETCH(ready at once) -> DECODE -> EXEC -> WB -> FETCH
        opcode = OP_REG; funct3 = 3'b000; funct7 = 7'b0000000; mem_ready = 1'b1; #1;
        chk("add_fetch_state", 32'(a_state), 1);
        chk("add_fetch_ifetch", 32'({a_mem_req, a_ifetch, a_ir_write, a_mem_write}), 4'b1110);
        cyc(); mem_ready = 1'b0; #1;
        chk("add_decode_state", 32'(a_state), 2);
        chk("add_decode_pcw", 32'(a_pc_write), 0);
        cyc();
        chk("add_exec_state", 32'(a_state), 3);
        chk("add_exec_aluop", 32'(a_alu_op), 2);
        chk("add_exec_regw", 32'(a_reg_write), 0);
        cyc();
        chk("add_wb_state", 32'(a_state), 6);
        chk("add_wb_strobes", 32'({a_reg_write, a_pc_write}), 2'b11);
        cyc();
        chk("add_back_fetch", 32'(a_state), 1);
        chk("add_fetch_regw", 32'(a_reg_write), 0);

        // sw: four MEM cycles, ready on the 4th (coincides with timeout in a)
        opcode = OP_STORE; funct3 = 3'b010; mem_ready = 1'b1; #1;
        cyc(); mem_ready = 1'b0;
        cyc();
        chk("sw_exec_state", 32'(a_state), 3);
        chk("sw_exec_imm", 32'({a_imm_src, a_alu_src, a_alu_op}), 6'b011_1_00);
        cyc();
        chk("sw_mem1", 32'({a_state, a_mem_req, a_mem_write, a_pc_write, a_reg_write}), 7'b100_1100);
        cyc();
        chk("sw_mem2", 32'({a_state, a_mem_req, a_mem_write, a_pc_write}), 6'b100_110);
        cyc();
        chk("sw_mem3", 32'({a_state, a_mem_req, a_mem_write, a_pc_write}), 6'b100_110);
        cyc(); mem_ready = 1'b1; #1;
        chk("sw_mem4", 32'({a_state, a_mem_req, a_mem_write, a_pc_write, a_reg_write}), 7'b100_1110);
        chk("sw_mem4_b", 32'({b_state, b_mem_write, b_pc_write}), 5'b100_11);
        cyc(); mem_ready = 1'b0; #1;
        chk("sw_tie_no_trap", 32'(a_state), 1);

        // FETCH timeout: four FETCH cycles then TRAP cause 10
        chk("to_fetch1", 32'(a_state), 1);
        cyc(); cyc(); cyc();
        chk("to_fetch4", 32'(a_state), 1);
        cyc();
        chk("to_trap", 32'({a_state, a_trap, a_pc_write, a_mem_req}), 6'b111_110);
        chk("to_cause", 32'(a_trap_cause), 2);
        chk("to_b_still_fetch", 32'(b_state), 1);
        cyc();
        chk("to_after_trap", 32'({a_state, a_trap}), 4'b001_0);
        chk("to_cause_held", 32'(a_trap_cause), 2);

        // FETCH ready on the timeout cycle wins; the instruction is lbu
        cyc(); cyc(); cyc();
        opcode = OP_LOAD; funct3 = 3'b100; funct7 = 7'b0000000; mem_ready = 1'b1; #1;
        chk("tie_fetch4", 32'({a_state, a_ir_write}), 4'b001_1);
        cyc(); mem_ready = 1'b0; #1;
        chk("tie_no_trap", 32'(a_state), 2);
        cyc();
        chk("ld_exec_fields", 32'({a_result_src, a_imm_src, a_load_signed, a_imm_plus_src}), 7'b01_000_1_1);
        cyc();
        chk("ld_mem", 32'({a_state, a_mem_req, a_mem_write}), 5'b100_10);

        // Reset in the middle of a load's MEM phase
        rst = 1'b1;
        cyc();
        chk("rst_mem_state", 32'(a_state), 0);
        chk("rst_mem_outs_a", 32'(a_all), 0);
        chk("rst_mem_outs_b", 32'(b_all), 0);
        rst = 1'b0;
        cyc();
        chk("rst_mem_fetch", 32'(a_state), 1);

        // mul: a handshakes with mul/div, b traps as illegal
        opcode = OP_REG; funct3 = 3'b000; funct7 = 7'b0000001; mem_ready = 1'b1; #1;
        cyc(); mem_ready = 1'b0;
        cyc();
        chk("mul_exec", 32'({a_state, a_md_start, a_alu_op}), 6'b011_1_11);
        chk("mul_b_trap", 32'({b_state, b_trap, b_pc_write, b_trap_cause}), 7'b111_11_00);
        cyc();
        chk("mul_wait1", 32'({a_state, a_md_start}), 4'b101_0);
        chk("mul_b_fetch", 32'(b_state), 1);
        cyc(); cyc();
        chk("mul_wait3", 32'({a_state, a_reg_write}), 4'b101_0);
        md_done = 1'b1; #1;
        chk("mul_done", 32'(a_state), 5);
        cyc(); md_done = 1'b0; #1;
        chk("mul_wb", 32'({a_state, a_reg_write, a_pc_write}), 5'b110_11);
        cyc();
        chk("mul_back_fetch", 32'(a_state), 1);

        // ecall: a traps with cause 01, b treats it as illegal
        opcode = OP_SYSTEM; funct3 = 3'b000; funct7 = 7'b0000000; mem_ready = 1'b1; #1;
        cyc(); mem_ready = 1'b0;
        cyc();
        chk("ecall_a", 32'({a_state, a_trap, a_trap_cause}), 6'b111_1_01);
        chk("ecall_b", 32'({b_state, b_trap, b_trap_cause}), 6'b111_1_00);
        cyc();
        chk("ecall_after", 32'({a_state, a_trap, a_trap_cause}), 6'b001_0_01);

        // Reset during MULDIV
        opcode = OP_REG; funct3 = 3'b000; funct7 = 7'b0000001; mem_ready = 1'b1; #1;
        cyc(); mem_ready = 1'b0;
        cyc(); cyc();
        chk("md_rst_pre", 32'(a_state), 5);
        rst = 1'b1;
        cyc();
        chk("md_rst_outs", 32'(a_all), 0);
        rst = 1'b0;
        cyc();
        chk("md_rst_fetch", 32'(a_state), 1);

        // beq: branch + pcWrite in EXEC, then FETCH
        opcode = OP_BRANCH; funct3 = 3'b000; funct7 = 7'b0000000; mem_ready = 1'b1; #1;
        cyc(); mem_ready = 1'b0;
        cyc();
        chk("beq_exec", 32'({a_state, a_branch, a_pc_write, a_alu_op, a_imm_src}), 10'b011_1_1_01_101);
        cyc();
        chk("beq_fetch", 32'({a_state, a_branch, a_reg_write}), 5'b001_0_0);

        // fence: pcWrite in DECODE, straight back to FETCH
        opcode = OP_FENCE; mem_ready = 1'b1; #1;
        cyc(); mem_ready = 1'b0; #1;
        chk("fence_decode", 32'({a_state, a_pc_write}), 4'b010_1);
        cyc();
        chk("fence_fetch", 32'(a_state), 1);

        // jal: EXEC -> WB with o_jal and regWrite
        opcode = OP_JAL; mem_ready = 1'b1; #1;
        cyc(); mem_ready = 1'b0;
        cyc();
        chk("jal_exec", 32'({a_state, a_jal}), 4'b011_0);
        cyc();
        chk("jal_wb", 32'({a_state, a_jal, a_jalr, a_reg_write, a_result_src, a_imm_src}),
            11'b110_1_0_1_11_111);
        cyc();
        chk("jal_fetch", 32'(a_state), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
